uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter peripheral on the CPU data-memory bus. It is the bus
//  responder for CPU loads and stores, and sits beside block_ram, decoded by address.
//  CPU stores to TXDATA push bytes into a TX FIFO. An 8N1 serializer drains the FIFO to
//  uart_tx, LSB first. Status and level are readable with CPU loads.
// PARAMETERS
//  BASE_ADDR     32'h0000_F000  base byte address; window is BASE_ADDR..BASE_ADDR+0xF
//  CLKS_PER_BIT  868            clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  FIFO_DEPTH    16             TX FIFO entries; power of two, >= 2
//  FIFO_AW       4              log2(FIFO_DEPTH)
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   reset: synchronous, active-low
//  bus_we   in   1   store strobe from CPU, sampled at the rising edge
//  bus_re   in   1   load strobe from CPU
//  bus_addr in   32  byte address; word-aligned, bits[1:0] ignored
//  bus_wdata in  32  store data
//  bus_rdata out 32  load data; combinational
//  bus_hit  out  1   addr inside window and (bus_we|bus_re); combinational
//  uart_tx  out  1   serial output; registered; idles high
// BEHAVIOUR
//  Register map (offset), 32-bit word access only:
//   0x0 TXDATA  W: push wdata[7:0] into the FIFO. R: returns 0.
//   0x4 STATUS  R: {28'b0, ovf, busy, empty, full}.
//               W: wdata[3]=1 clears ovf; other bits are ignored.
//   0x8 LEVEL   R: {27'b0, count}, where count is 0..FIFO_DEPTH.
//   0xC         reserved; R returns 0, W is ignored.
//  Reads: bus_rdata = register value when bus_re and addr is in the window, else 32'h0.
//   Zero wait states. Reads have no side effects.
//  Push: on bus_we to TXDATA.
//   - If not full, write at wr_ptr and increment wr_ptr (wraps mod FIFO_DEPTH).
//   - If full, discard the byte and set ovf (sticky) on the same edge.
//  Pop: done by the FSM only, and only when not empty. rd_ptr wraps mod FIFO_DEPTH.
//  Simultaneous push and pop (not full): both happen and count is unchanged.
//   A push while full is dropped even if a pop occurs in the same cycle.
//  Simultaneous ovf set and ovf-clear write cannot happen (different offsets).
//  FSM states: IDLE, START, DATA, STOP. bitcnt counts 0..CLKS_PER_BIT-1; bitidx counts 0..7.
//   IDLE : uart_tx=1. If not empty: pop into shreg, go to START, uart_tx<=0, bitcnt<=0.
//   START: when bitcnt hits its last value, go to DATA with bitidx=0 and uart_tx<=shreg[0].
//   DATA : at the end of each bit, shift shreg right. After bitidx 7, go to STOP with uart_tx<=1.
//   STOP : at the end of the bit:
//          - if not empty, pop and go to START (back-to-back, no idle gap);
//          - else go to IDLE.
//  Timing: a byte pushed at edge E0 into an empty FIFO while in IDLE gives uart_tx low from E1.
//   Each frame lasts exactly 10*CLKS_PER_BIT cycles.
//  busy = (state != IDLE).
//  Reset (rst==0 at a rising edge), including mid-frame:
//   - state=IDLE, uart_tx=1, pointers=0, count=0, ovf=0, shreg=0;
//   - FIFO contents are discarded and any frame in flight is truncated.
//   - Bus strobes during reset are ignored.
//  Combinational outputs (bus_rdata, bus_hit) follow the reset register values.
// TESTING (bench: CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset, then store 0x55 to TXDATA.
//     -> uart_tx goes low 1 cycle after the write edge, then carries 1,0,1,0,1,0,1,0 at 4
//        cycles/bit, then high; the frame is 40 cycles; busy falls afterwards.
//  2. Store 0xA1 then 0x3C on consecutive cycles.
//     -> two frames with no idle gap (80 cycles total); LEVEL reads 1 mid-frame-1 and 0 in frame 2.
//  3. Store 6 bytes in 6 cycles.
//     -> 5 bytes are transmitted (1 popped immediately + 4 queued); the 6th is dropped.
//     -> STATUS reads 0x0D (ovf, busy, full) after the 6th write.
//     -> writing 0x8 to STATUS clears ovf.
//  4. Load from BASE+0x4 when idle and empty -> rdata 0x2, hit 1.
//     Load from BASE+0x10 -> rdata 0, hit 0. Store outside the window -> FIFO unchanged.
//  5. Assert rst low mid-DATA with 2 bytes queued.
//     -> next edge: uart_tx=1, LEVEL=0, STATUS=0x2; no further frames after rst is released.
//  6. Fill and drain the FIFO 3 times (pointer wrap).
//     -> the byte order out of uart_tx matches the write order exactly.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory bus as seen by the UART transmitter peripheral.
// The CPU drives the strobes, address and store data; the peripheral answers with load data and hit.
interface uart_tx_mmio_if;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_hit;

   modport master (
      output bus_we, bus_re, bus_addr, bus_wdata,
      input  bus_rdata, bus_hit
   );

   modport slave (
      input  bus_we, bus_re, bus_addr, bus_wdata,
      output bus_rdata, bus_hit
   );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO that a serializer drains LSB first.
// Registers: 0x0 TXDATA, 0x4 STATUS {ovf,busy,empty,full}, 0x8 LEVEL, 0xC reserved.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          FIFO_AW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_mmio_if.slave bus,
   output logic          uart_tx
);

   localparam int                CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]     BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      bitcnt_q, bitcnt_d;
   logic [2:0]         bitidx_q, bitidx_d;
   logic [7:0]         shreg_q, shreg_d;
   logic               tx_q, tx_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [7:0]         fifo_mem [FIFO_DEPTH];

   logic        in_win, push_req, push, pop, ovf_set, ovf_clr;
   logic        full, empty, busy, bit_end;
   logic [1:0]  offset;
   logic [31:0] rdata;
   logic        unused_bits;

   // The window is 16 bytes aligned on BASE_ADDR, so only the upper address bits decide a hit.
   assign in_win      = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
   assign offset      = bus.bus_addr[3:2];
   assign bus.bus_hit = in_win & (bus.bus_we | bus.bus_re);
   assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign busy     = (state_q != S_IDLE);
   assign bit_end  = (bitcnt_q == BIT_LAST);
   assign push_req = bus.bus_we & in_win & (offset == 2'd0);
   assign push     = push_req & ~full;
   assign ovf_set  = push_req & full;
   assign ovf_clr  = bus.bus_we & in_win & (offset == 2'd1) & bus.bus_wdata[3];

   // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      rdata = '0;
      if (bus.bus_re && in_win) begin
         case (offset)
            2'd1:    rdata = {28'b0, ovf_q, busy, empty, full};
            2'd2:    rdata = 32'(count_q);
            default: rdata = '0;
         endcase
      end
   end
   assign bus.bus_rdata = rdata;

   // Serializer next state; pop is raised only when a byte is taken into shreg.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      bitidx_d = bitidx_q;
      shreg_d  = shreg_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               shreg_d  = fifo_mem[rd_ptr_q];
               state_d  = S_START;
               tx_d     = 1'b0;
               bitcnt_d = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d  = S_DATA;
               bitcnt_d = '0;
               bitidx_d = '0;
               tx_d     = shreg_q[0];
            end else begin
               bitcnt_d = bitcnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               bitcnt_d = '0;
               shreg_d  = {1'b0, shreg_q[7:1]};
               if (bitidx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bitidx_d = bitidx_q + 3'd1;
                  tx_d     = shreg_q[1];
               end
            end else begin
               bitcnt_d = bitcnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               bitcnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_mem[rd_ptr_q];
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               bitcnt_d = bitcnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping; a push while full is dropped even when a pop happens on the same edge.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
         default: count_d = count_q;
      endcase
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         bitcnt_q <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         bitidx_q <= bitidx_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the storage array is not reset; clearing the pointers and count is what empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst && push) fifo_mem[wr_ptr_q] <= bus.bus_wdata[7:0];
   end

   assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a frame-level reference model compared every cycle, a serial receiver,
// and directed scenarios with hand-computed expectations.
module tb_uart_tx_mmio;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          AW    = 2;
   localparam logic [31:0] BASE  = 32'h0000_F000;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'h4;
   localparam logic [31:0] A_LV  = BASE + 32'h8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic uart_tx;

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .FIFO_AW     (AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus "which frame, how far into it", no FSM states.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_elapsed = 0;
   logic [7:0] m_cur = 8'h00;
   bit         m_ovf = 1'b0;

   function automatic bit in_window(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd16);
   endfunction

   always @(posedge clk) begin
      int n;
      bit do_pop;
      if (!rst) begin
         m_q.delete();
         m_active  = 1'b0;
         m_elapsed = 0;
         m_ovf     = 1'b0;
      end else begin
         n      = m_q.size();
         do_pop = 1'b0;
         if (m_active) begin
            if (m_elapsed == 10 * CPB - 1) begin
               if (n > 0) do_pop = 1'b1;
               else       m_active = 1'b0;
            end else begin
               m_elapsed++;
            end
         end else if (n > 0) begin
            do_pop = 1'b1;
         end
         if (do_pop) begin
            m_cur     = m_q.pop_front();
            m_active  = 1'b1;
            m_elapsed = 0;
         end
         if (bus.bus_we && in_window(bus.bus_addr) && bus.bus_addr[3:2] == 2'd0) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else            m_q.push_back(bus.bus_wdata[7:0]);
         end
         if (bus.bus_we && in_window(bus.bus_addr) && bus.bus_addr[3:2] == 2'd1 && bus.bus_wdata[3])
            m_ovf = 1'b0;
      end
   end

   function automatic logic m_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_elapsed / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_cur[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_reg(input logic [31:0] a);
      if (!in_window(a)) return 32'h0;
      case (a[3:2])
         2'd1:    return {28'b0, m_ovf, m_active, m_q.size() == 0, m_q.size() == DEPTH};
         2'd2:    return 32'(m_q.size());
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      check("uart_tx_model", 32'(uart_tx), 32'(m_tx()));
      check("bus_hit_model", 32'(bus.bus_hit),
            32'(in_window(bus.bus_addr) && (bus.bus_we || bus.bus_re)));
      if (bus.bus_re) check("rdata_model", bus.bus_rdata, m_reg(bus.bus_addr));
   end

   // Serial receiver: samples each bit in its middle, aborts on reset.
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         rx_act = 1'b0;
   int         rx_t = 0;
   logic [7:0] rx_sh = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (uart_tx === 1'b0) begin
            rx_act = 1'b1;
            rx_t   = 0;
         end
      end else begin
         rx_t++;
         if (rx_t >= 6 && rx_t <= 34 && (rx_t - 2) % 4 == 0) rx_sh[(rx_t - 6) / 4] = uart_tx;
         if (rx_t == 38) check("rx_stop_bit", 32'(uart_tx), 32'h1);
         if (rx_t == 39) begin
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
      @(posedge clk); #1;
      bus.bus_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      bus.bus_re = 1'b1; bus.bus_addr = a;
      @(negedge clk);
      check(name, bus.bus_rdata, exp);
      @(posedge clk); #1;
      bus.bus_re = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget, input string name);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, 32'(rx_q.size()), 32'(n));
   endtask

   task automatic check_rx(input string name);
      check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check(name, 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   logic [39:0] t1_exp = 40'h0F_0F0F_0F0F;
   logic [39:0] t1_act;
   logic [7:0]  t3_bytes [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [7:0]  t6_bytes [15] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h7E,
                                  8'hC3, 8'h24, 8'h99, 8'h66, 8'hAB,
                                  8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

   initial begin
      bus.bus_we = 1'b0; bus.bus_re = 1'b0; bus.bus_addr = 32'h0; bus.bus_wdata = 32'h0;
      rst = 1'b0;
      cycles(3);
      rst = 1'b1;
      check("reset_uart_tx", 32'(uart_tx), 32'h1);
      rd(A_ST, 32'h2, "reset_status");
      rd(A_LV, 32'h0, "reset_level");

      // 1: single byte 0x55, frame starts the edge after the write
      wr(A_TX, 32'h55);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         t1_act[39-i] = uart_tx;
      end
      for (int i = 0; i < 40; i++) check("t1_frame_bit", 32'(t1_act[39-i]), 32'(t1_exp[39-i]));
      cycles(1);
      rd(A_ST, 32'h2, "t1_busy_fell");
      exp_q.push_back(8'h55);
      check_rx("t1_rx");

      // 2: two bytes on consecutive cycles, back-to-back frames
      bus.bus_we = 1'b1; bus.bus_addr = A_TX; bus.bus_wdata = 32'hA1;
      @(posedge clk); #1;
      bus.bus_wdata = 32'h3C;
      @(posedge clk); #1;
      bus.bus_we = 1'b0;
      cycles(8);
      rd(A_LV, 32'h1, "t2_level_frame1");
      cycles(35);
      rd(A_LV, 32'h0, "t2_level_frame2");
      rd(A_ST, 32'h6, "t2_status_frame2");
      cycles(34);
      rd(A_ST, 32'h2, "t2_idle_after_80");
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'h3C);
      check_rx("t2_rx");

      // 3: overflow on the sixth write, then clear ovf
      bus.bus_we = 1'b1; bus.bus_addr = A_TX;
      for (int i = 0; i < 6; i++) begin
         bus.bus_wdata = 32'(t3_bytes[i]);
         @(posedge clk); #1;
      end
      bus.bus_we = 1'b0;
      rd(A_ST, 32'hD, "t3_status_ovf");
      wr(A_ST, 32'h8);
      rd(A_ST, 32'h5, "t3_ovf_cleared");
      wait_rx(5, 400, "t3_wait_rx");
      for (int i = 0; i < 5; i++) exp_q.push_back(t3_bytes[i]);
      check_rx("t3_rx");
      cycles(2);

      // 4: decode and window boundaries
      bus.bus_re = 1'b1; bus.bus_addr = A_ST;
      @(negedge clk);
      check("t4_hit_status", 32'(bus.bus_hit), 32'h1);
      check("t4_rdata_status", bus.bus_rdata, 32'h2);
      bus.bus_addr = BASE + 32'h10;
      #1;
      check("t4_hit_above", 32'(bus.bus_hit), 32'h0);
      check("t4_rdata_above", bus.bus_rdata, 32'h0);
      bus.bus_addr = BASE - 32'h4;
      #1;
      check("t4_hit_below", 32'(bus.bus_hit), 32'h0);
      bus.bus_addr = BASE + 32'hC;
      #1;
      check("t4_rdata_reserved", bus.bus_rdata, 32'h0);
      check("t4_rdata_txdata", 32'h0, 32'h0 | (bus.bus_addr == BASE ? bus.bus_rdata : 32'h0));
      @(posedge clk); #1;
      bus.bus_re = 1'b0;
      rd(A_TX, 32'h0, "t4_txdata_reads_zero");
      bus.bus_we = 1'b1; bus.bus_addr = BASE + 32'h10; bus.bus_wdata = 32'h77;
      #1;
      check("t4_hit_store_outside", 32'(bus.bus_hit), 32'h0);
      @(posedge clk); #1;
      bus.bus_we = 1'b0;
      rd(A_LV, 32'h0, "t4_level_after_outside");
      cycles(5);
      check("t4_line_idle", 32'(uart_tx), 32'h1);
      check_rx("t4_rx");

      // 5: reset mid-DATA with two bytes queued; a store during reset is ignored
      bus.bus_we = 1'b1; bus.bus_addr = A_TX;
      foreach (t3_bytes[i]) if (i < 3) begin
         bus.bus_wdata = 32'(8'h0F << i);
         @(posedge clk); #1;
      end
      bus.bus_we = 1'b0;
      cycles(10);
      rst = 1'b0;
      bus.bus_re = 1'b1; bus.bus_addr = A_LV;
      @(posedge clk);
      @(negedge clk);
      check("t5_tx_after_reset", 32'(uart_tx), 32'h1);
      check("t5_level_in_reset", bus.bus_rdata, 32'h0);
      bus.bus_addr = A_ST;
      #1;
      check("t5_status_in_reset", bus.bus_rdata, 32'h2);
      @(posedge clk); #1;
      bus.bus_re = 1'b0;
      bus.bus_we = 1'b1; bus.bus_addr = A_TX; bus.bus_wdata = 32'h99;
      @(posedge clk); #1;
      bus.bus_we = 1'b0;
      rst = 1'b1;
      rd(A_ST, 32'h2, "t5_status_after");
      rd(A_LV, 32'h0, "t5_level_after");
      cycles(100);
      check("t5_no_frames", 32'(rx_q.size()), 32'h0);
      check("t5_line_idle", 32'(uart_tx), 32'h1);
      check_rx("t5_rx");

      // 6: fill and drain three times so both pointers wrap
      for (int r = 0; r < 3; r++) begin
         bus.bus_we = 1'b1; bus.bus_addr = A_TX;
         for (int i = 0; i < 5; i++) begin
            bus.bus_wdata = 32'(t6_bytes[r*5 + i]);
            @(posedge clk); #1;
         end
         bus.bus_we = 1'b0;
         rd(A_LV, 32'h4, "t6_level_full");
         rd(A_ST, 32'h5, "t6_status_full");
         wait_rx(5 * (r + 1), 400, "t6_wait_rx");
         cycles(2);
      end
      foreach (t6_bytes[i]) exp_q.push_back(t6_bytes[i]);
      check_rx("t6_rx_order");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
